// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM controller request port between the
// cart download, core and aux (savestate / save flush) requesters.
// Request pulses are latched per channel, one controller access runs at a time,
// and the completion is routed back to the channel that owns the access.
// Optional WAIT watchdog: define SDRAM_ARB_TIMEOUT_EN.
module sdram_arbiter #(
    parameter int ADDR_W       = 27,
    parameter int STARVE_LIMIT = 8,
    parameter int TIMEOUT      = 4096
) (
    input  logic              clk1x,
    input  logic              reset,
    input  logic              dl_req,
    input  logic [ADDR_W-1:0] dl_addr,
    input  logic [31:0]       dl_din,
    output logic              dl_ready,
    input  logic              core_req,
    input  logic              core_rnw,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [3:0]        core_be,
    input  logic [31:0]       core_din,
    output logic [31:0]       core_dout,
    output logic              core_ready,
    input  logic              aux_req,
    input  logic              aux_rnw,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [3:0]        aux_be,
    input  logic [31:0]       aux_din,
    output logic [31:0]       aux_dout,
    output logic              aux_ready,
    output logic              mem_ena,
    output logic              mem_rnw,
    output logic [ADDR_W-1:0] mem_Adr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_dataWrite,
    input  logic              mem_done,
    input  logic [31:0]       mem_dataRead,
    output logic              drop_err,
    output logic              timeout_err
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic [1:0] CH_DL   = 2'd0;
    localparam logic [1:0] CH_CORE = 2'd1;
    localparam logic [1:0] CH_AUX  = 2'd2;

    logic [1:0]        state;
    logic [1:0]        owner;
    logic [1:0]        winner;
    logic              dl_pend, core_pend, aux_pend;
    logic              any_pend, aux_forced;
    logic [ADDR_W-1:0] dl_addr_q, core_addr_q, aux_addr_q;
    logic [31:0]       dl_din_q, core_din_q, aux_din_q;
    logic [3:0]        core_be_q, aux_be_q;
    logic              core_rnw_q, aux_rnw_q;
    logic [7:0]        starve_cnt;
    logic              finish, timed_out;
    logic              dl_clear, core_clear, aux_clear;
    logic              dl_take, core_take, aux_take;

    assign any_pend   = dl_pend | core_pend | aux_pend;
    assign aux_forced = aux_pend && (starve_cnt >= 8'(STARVE_LIMIT));

    // The owner's access ends on a controller completion (or watchdog abort) in WAIT.
    assign finish     = (state == ST_WAIT) && (mem_done || timed_out);
    assign dl_clear   = finish && (owner == CH_DL);
    assign core_clear = finish && (owner == CH_CORE);
    assign aux_clear  = finish && (owner == CH_AUX);

    // A request is accepted when its channel is idle or is completing on this very edge.
    assign dl_take   = dl_req   && (!dl_pend   || dl_clear);
    assign core_take = core_req && (!core_pend || core_clear);
    assign aux_take  = aux_req  && (!aux_pend  || aux_clear);

    // Pick the next owner: download first, then core unless aux has been starved too long.
    always_comb begin
        winner = CH_CORE;
        if (dl_pend)
            winner = CH_DL;
        else if (core_pend && !aux_forced)
            winner = CH_CORE;
        else if (aux_pend)
            winner = CH_AUX;
    end

`ifdef SDRAM_ARB_TIMEOUT_EN
    logic [12:0] wdog;

    assign timed_out = (state == ST_WAIT) && !mem_done && (wdog == 13'(TIMEOUT - 1));

    // Watchdog counts cycles spent waiting for the controller and restarts outside WAIT.
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset)
            wdog <= 13'd0;
        else if (state != ST_WAIT)
            wdog <= 13'd0;
        else
            wdog <= wdog + 13'd1;
    end

    // Sticky record that an access had to be aborted.
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset)
            timeout_err <= 1'b0;
        else if (timed_out)
            timeout_err <= 1'b1;
    end
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // Pending flags and request latches; a completing flag is cleared before a new set.
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset) begin
            dl_pend     <= 1'b0;
            core_pend   <= 1'b0;
            aux_pend    <= 1'b0;
            dl_addr_q   <= '0;
            dl_din_q    <= 32'd0;
            core_addr_q <= '0;
            core_din_q  <= 32'd0;
            core_be_q   <= 4'd0;
            core_rnw_q  <= 1'b0;
            aux_addr_q  <= '0;
            aux_din_q   <= 32'd0;
            aux_be_q    <= 4'd0;
            aux_rnw_q   <= 1'b0;
        end else begin
            if (dl_clear)   dl_pend   <= 1'b0;
            if (core_clear) core_pend <= 1'b0;
            if (aux_clear)  aux_pend  <= 1'b0;
            if (dl_take) begin
                dl_pend   <= 1'b1;
                dl_addr_q <= dl_addr;
                dl_din_q  <= dl_din;
            end
            if (core_take) begin
                core_pend   <= 1'b1;
                core_addr_q <= core_addr;
                core_din_q  <= core_din;
                core_be_q   <= core_be;
                core_rnw_q  <= core_rnw;
            end
            if (aux_take) begin
                aux_pend   <= 1'b1;
                aux_addr_q <= aux_addr;
                aux_din_q  <= aux_din;
                aux_be_q   <= aux_be;
                aux_rnw_q  <= aux_rnw;
            end
        end
    end

    // Sticky flag for any request that arrived while its channel was still busy.
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset)
            drop_err <= 1'b0;
        else if ((dl_req && !dl_take) || (core_req && !core_take) || (aux_req && !aux_take))
            drop_err <= 1'b1;
    end

    // Count core grants made while aux waits; any aux grant or idle aux channel clears it.
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset)
            starve_cnt <= 8'd0;
        else if (!aux_pend)
            starve_cnt <= 8'd0;
        else if ((state == ST_IDLE) && any_pend) begin
            if (winner == CH_AUX)
                starve_cnt <= 8'd0;
            else if (winner == CH_CORE)
                starve_cnt <= starve_cnt + 8'd1;
        end
    end

    // Sequencer: grant in IDLE, one-cycle strobe through ISSUE, route completion in WAIT.
    always_ff @(posedge clk1x or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            owner         <= CH_CORE;
            mem_ena       <= 1'b0;
            mem_rnw       <= 1'b0;
            mem_Adr       <= '0;
            mem_be        <= 4'd0;
            mem_dataWrite <= 32'd0;
            dl_ready      <= 1'b0;
            core_ready    <= 1'b0;
            aux_ready     <= 1'b0;
            core_dout     <= 32'd0;
            aux_dout      <= 32'd0;
        end else begin
            mem_ena    <= 1'b0;
            dl_ready   <= 1'b0;
            core_ready <= 1'b0;
            aux_ready  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (any_pend) begin
                        owner   <= winner;
                        mem_ena <= 1'b1;
                        state   <= ST_ISSUE;
                        case (winner)
                            CH_DL: begin
                                mem_rnw       <= 1'b0;
                                mem_Adr       <= dl_addr_q;
                                mem_be        <= 4'hF;
                                mem_dataWrite <= dl_din_q;
                            end
                            CH_AUX: begin
                                mem_rnw       <= aux_rnw_q;
                                mem_Adr       <= aux_addr_q;
                                mem_be        <= aux_be_q;
                                mem_dataWrite <= aux_din_q;
                            end
                            default: begin
                                mem_rnw       <= core_rnw_q;
                                mem_Adr       <= core_addr_q;
                                mem_be        <= core_be_q;
                                mem_dataWrite <= core_din_q;
                            end
                        endcase
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (finish) begin
                        state <= ST_IDLE;
                        case (owner)
                            CH_DL: dl_ready <= 1'b1;
                            CH_AUX: begin
                                aux_ready <= 1'b1;
                                aux_dout  <= timed_out ? 32'hDEADDEAD : mem_dataRead;
                            end
                            default: begin
                                core_ready <= 1'b1;
                                core_dout  <= timed_out ? 32'hDEADDEAD : mem_dataRead;
                            end
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter with a small controller model.
// Build with SDRAM_ARB_TIMEOUT_EN defined to exercise the watchdog path.
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int ADDR_W = 27;

    logic              clk1x = 1'b0;
    logic              reset = 1'b1;
    logic              dl_req = 1'b0;
    logic [ADDR_W-1:0] dl_addr = '0;
    logic [31:0]       dl_din = 32'd0;
    logic              dl_ready;
    logic              core_req = 1'b0;
    logic              core_rnw = 1'b0;
    logic [ADDR_W-1:0] core_addr = '0;
    logic [3:0]        core_be = 4'd0;
    logic [31:0]       core_din = 32'd0;
    logic [31:0]       core_dout;
    logic              core_ready;
    logic              aux_req = 1'b0;
    logic              aux_rnw = 1'b0;
    logic [ADDR_W-1:0] aux_addr = '0;
    logic [3:0]        aux_be = 4'd0;
    logic [31:0]       aux_din = 32'd0;
    logic [31:0]       aux_dout;
    logic              aux_ready;
    logic              mem_ena;
    logic              mem_rnw;
    logic [ADDR_W-1:0] mem_Adr;
    logic [3:0]        mem_be;
    logic [31:0]       mem_dataWrite;
    logic              mem_done;
    logic [31:0]       mem_dataRead;
    logic              drop_err;
    logic              timeout_err;

    sdram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(8), .TIMEOUT(16)) dut (
        .clk1x(clk1x), .reset(reset),
        .dl_req(dl_req), .dl_addr(dl_addr), .dl_din(dl_din), .dl_ready(dl_ready),
        .core_req(core_req), .core_rnw(core_rnw), .core_addr(core_addr), .core_be(core_be),
        .core_din(core_din), .core_dout(core_dout), .core_ready(core_ready),
        .aux_req(aux_req), .aux_rnw(aux_rnw), .aux_addr(aux_addr), .aux_be(aux_be),
        .aux_din(aux_din), .aux_dout(aux_dout), .aux_ready(aux_ready),
        .mem_ena(mem_ena), .mem_rnw(mem_rnw), .mem_Adr(mem_Adr), .mem_be(mem_be),
        .mem_dataWrite(mem_dataWrite), .mem_done(mem_done), .mem_dataRead(mem_dataRead),
        .drop_err(drop_err), .timeout_err(timeout_err)
    );

    always #5 clk1x = ~clk1x;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        rnw;
        logic [3:0]  be;
        logic [31:0] data;
    } grant_t;

    grant_t      grantQ[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          stimCyc = 0;
    int          doneCyc = 0;
    int          dlReadyCyc = 0, coreReadyCyc = 0, auxReadyCyc = 0;
    int          dlReadyCnt = 0, coreReadyCnt = 0, auxReadyCnt = 0;
    int          respDelay = 5;
    int          respCnt = 0;
    bit          respEnable = 1'b1;
    bit          manualDone = 1'b0;
    logic [31:0] respData = 32'd0;

    // Cycle stamp used to time every observation.
    always @(posedge clk1x) cyc <= cyc + 1;

    // Record every controller strobe and every ready pulse, sampled mid-cycle.
    always @(negedge clk1x) begin
        grant_t g;
        if (mem_ena) begin
            g.cyc  = cyc;
            g.addr = 32'(mem_Adr);
            g.rnw  = mem_rnw;
            g.be   = mem_be;
            g.data = mem_dataWrite;
            grantQ.push_back(g);
        end
        if (dl_ready)   begin dlReadyCnt++;   dlReadyCyc = cyc;   end
        if (core_ready) begin coreReadyCnt++; coreReadyCyc = cyc; end
        if (aux_ready)  begin auxReadyCnt++;  auxReadyCyc = cyc;  end
    end

    // Controller model: answers each strobe respDelay cycles later, or on demand.
    initial begin
        mem_done     = 1'b0;
        mem_dataRead = 32'd0;
        forever begin
            @(negedge clk1x);
            mem_done = 1'b0;
            if (manualDone) begin
                mem_done     = 1'b1;
                mem_dataRead = respData;
                manualDone   = 1'b0;
                doneCyc      = cyc;
            end else if (respCnt > 0) begin
                respCnt--;
                if (respCnt == 0) begin
                    mem_done     = 1'b1;
                    mem_dataRead = respData;
                    doneCyc      = cyc;
                end
            end
            if (mem_ena && respEnable) respCnt = respDelay;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Pulse the selected requests (mask order dl, core, aux) for one cycle.
    task automatic applyStimulus(input logic [2:0] mask);
        @(negedge clk1x);
        dl_req   = mask[2];
        core_req = mask[1];
        aux_req  = mask[0];
        stimCyc  = cyc;
        @(negedge clk1x);
        dl_req   = 1'b0;
        core_req = 1'b0;
        aux_req  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk1x);
    endtask

    function automatic grant_t getGrant(input int i);
        grant_t g;
        g = '{cyc: -1, addr: 32'hFFFF_FFFF, rnw: 1'bx, be: 4'hx, data: 32'hFFFF_FFFF};
        if (i < grantQ.size()) g = grantQ[i];
        return g;
    endfunction

    initial begin
        grant_t g;
        int     base;
        int     gsz;

        // Reset state
        waitCycles(3);
        checkOutput("reset_ctrl", 32'({mem_ena, mem_rnw, mem_be, dl_ready, core_ready, aux_ready,
                                       drop_err, timeout_err}), 32'd0);
        checkOutput("reset_adr", 32'(mem_Adr), 32'd0);
        checkOutput("reset_core_dout", core_dout, 32'd0);
        reset = 1'b0;
        waitCycles(2);

        // Single core read
        $display("[TB] single core read");
        grantQ.delete();
        respDelay = 5;
        respData  = 32'h12345678;
        core_rnw  = 1'b1; core_addr = 27'h0800010; core_be = 4'hF; core_din = 32'd0;
        applyStimulus(3'b010);
        waitCycles(12);
        checkOutput("t1_grants", 32'(grantQ.size()), 32'd1);
        g = getGrant(0);
        checkOutput("t1_ena_latency", 32'(g.cyc - stimCyc), 32'd2);
        checkOutput("t1_addr", g.addr, 32'h0800010);
        checkOutput("t1_rnw", 32'(g.rnw), 32'd1);
        checkOutput("t1_ready_latency", 32'(coreReadyCyc - doneCyc), 32'd1);
        checkOutput("t1_ready_count", 32'(coreReadyCnt), 32'd1);
        checkOutput("t1_core_dout", core_dout, 32'h12345678);

        // Three channels in one cycle
        $display("[TB] simultaneous dl/core/aux");
        grantQ.delete();
        respDelay = 3;
        respData  = 32'hCAFEF00D;
        dl_addr   = 27'h0000100; dl_din = 32'hA5A5A5A5;
        core_rnw  = 1'b0; core_addr = 27'h0800020; core_be = 4'h3; core_din = 32'h11112222;
        aux_rnw   = 1'b1; aux_addr = 27'h1000040; aux_be = 4'hF; aux_din = 32'd0;
        applyStimulus(3'b111);
        waitCycles(30);
        checkOutput("t2_grants", 32'(grantQ.size()), 32'd3);
        g = getGrant(0);
        checkOutput("t2_dl_latency", 32'(g.cyc - stimCyc), 32'd2);
        checkOutput("t2_dl_addr", g.addr, 32'h0000100);
        checkOutput("t2_dl_wr", 32'({g.rnw, g.be}), 32'h0F);
        checkOutput("t2_dl_data", g.data, 32'hA5A5A5A5);
        g = getGrant(1);
        checkOutput("t2_core_addr", g.addr, 32'h0800020);
        checkOutput("t2_core_be", 32'({g.rnw, g.be}), 32'h03);
        checkOutput("t2_core_data", g.data, 32'h11112222);
        checkOutput("t2_core_after_dl", 32'(g.cyc - dlReadyCyc), 32'd1);
        g = getGrant(2);
        checkOutput("t2_aux_addr", g.addr, 32'h1000040);
        checkOutput("t2_aux_rnw", 32'(g.rnw), 32'd1);
        checkOutput("t2_aux_after_core", 32'(g.cyc - coreReadyCyc), 32'd1);
        checkOutput("t2_aux_ready_latency", 32'(auxReadyCyc - doneCyc), 32'd1);
        checkOutput("t2_aux_dout", aux_dout, 32'hCAFEF00D);
        checkOutput("t2_core_dout", core_dout, 32'hCAFEF00D);
        checkOutput("t2_no_drop", 32'(drop_err), 32'd0);

        // Second core request while the first is outstanding
        $display("[TB] drop");
        grantQ.delete();
        base     = coreReadyCnt;
        core_rnw = 1'b1; core_addr = 27'h0800100; core_be = 4'hF;
        applyStimulus(3'b010);
        core_addr = 27'h0800200;
        applyStimulus(3'b010);
        waitCycles(20);
        checkOutput("t3_drop_err", 32'(drop_err), 32'd1);
        checkOutput("t3_grants", 32'(grantQ.size()), 32'd1);
        checkOutput("t3_addr", getGrant(0).addr, 32'h0800100);
        checkOutput("t3_ready_count", 32'(coreReadyCnt - base), 32'd1);

        // Aux starvation against a continuously requesting core
        $display("[TB] starvation");
        grantQ.delete();
        base     = auxReadyCnt;
        core_rnw = 1'b1; core_addr = 27'h0800300;
        aux_rnw  = 1'b1; aux_addr = 27'h1000300;
        @(negedge clk1x);
        core_req = 1'b1;
        aux_req  = 1'b1;
        @(negedge clk1x);
        aux_req  = 1'b0;
        waitCycles(60);
        core_req = 1'b0;
        waitCycles(20);
        checkOutput("t4_enough_grants", 32'(grantQ.size() >= 9), 32'd1);
        for (int i = 0; i < 8; i++)
            checkOutput($sformatf("t4_core_grant%0d", i), getGrant(i).addr, 32'h0800300);
        checkOutput("t4_aux_grant", getGrant(8).addr, 32'h1000300);
        checkOutput("t4_aux_ready_count", 32'(auxReadyCnt - base), 32'd1);

        // Reset in WAIT followed by a stale completion
        $display("[TB] reset during wait");
        respEnable = 1'b0;
        core_rnw   = 1'b1; core_addr = 27'h0800400;
        applyStimulus(3'b010);
        waitCycles(4);
        reset = 1'b1;
        @(negedge clk1x);
        checkOutput("t5_rst_ctrl", 32'({mem_ena, mem_rnw, mem_be, dl_ready, core_ready, aux_ready,
                                        drop_err, timeout_err}), 32'd0);
        checkOutput("t5_rst_adr", 32'(mem_Adr), 32'd0);
        checkOutput("t5_rst_wdata", mem_dataWrite, 32'd0);
        checkOutput("t5_rst_core_dout", core_dout, 32'd0);
        checkOutput("t5_rst_aux_dout", aux_dout, 32'd0);
        reset = 1'b0;
        base  = coreReadyCnt;
        gsz   = grantQ.size();
        respData   = 32'h77777777;
        manualDone = 1'b1;
        waitCycles(6);
        checkOutput("t5_stale_done_ready", 32'(coreReadyCnt - base), 32'd0);
        checkOutput("t5_stale_done_ena", 32'(grantQ.size() - gsz), 32'd0);
        grantQ.delete();
        respEnable = 1'b1;
        respDelay  = 3;
        respData   = 32'h0BADBEEF;
        core_addr  = 27'h0800500;
        applyStimulus(3'b010);
        waitCycles(12);
        checkOutput("t5_after_grants", 32'(grantQ.size()), 32'd1);
        checkOutput("t5_after_latency", 32'(getGrant(0).cyc - stimCyc), 32'd2);
        checkOutput("t5_after_addr", getGrant(0).addr, 32'h0800500);
        checkOutput("t5_after_dout", core_dout, 32'h0BADBEEF);

        // Controller never answers an aux read
        $display("[TB] no completion");
        respEnable = 1'b0;
        base       = auxReadyCnt;
        aux_rnw    = 1'b1; aux_addr = 27'h1000500;
        applyStimulus(3'b001);
`ifdef SDRAM_ARB_TIMEOUT_EN
        waitCycles(25);
        checkOutput("t6_ready_count", 32'(auxReadyCnt - base), 32'd1);
        checkOutput("t6_ready_cycle", 32'(auxReadyCyc - stimCyc), 32'd19);
        checkOutput("t6_aux_dout", aux_dout, 32'hDEADDEAD);
        checkOutput("t6_timeout_err", 32'(timeout_err), 32'd1);
`else
        waitCycles(40);
        checkOutput("t6_still_waiting", 32'(auxReadyCnt - base), 32'd0);
        checkOutput("t6_timeout_err", 32'(timeout_err), 32'd0);
        respData   = 32'h55AA55AA;
        manualDone = 1'b1;
        waitCycles(4);
        checkOutput("t6_late_ready", 32'(auxReadyCnt - base), 32'd1);
        checkOutput("t6_aux_dout", aux_dout, 32'h55AA55AA);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller request port between three requesters: cart download, core ROM/SRAM/Flash access, and an aux channel for savestate or save-memory flush.
- Replaces direct per-channel wiring to the controller; sits in the top level between the requesters and sdram ch1.
- Latches one-cycle request pulses, arbitrates, issues exactly one controller request at a time, and routes the completion back to the owning requester.

Parameters:
- ADDR_W, 27, address width for all channels and the controller port.
- STARVE_LIMIT, 8, consecutive core grants allowed while aux is pending before aux is forced (range 1..255).
- TIMEOUT, 4096, watchdog limit in cycles; used only with the optional feature.

Ports:
- clk1x  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- dl_req  in  1  download request pulse.
- dl_addr  in  ADDR_W  download word address.
- dl_din  in  32  download write data.
- dl_ready  out  1  download done pulse.
- core_req  in  1  core request pulse.
- core_rnw  in  1  core access type: 1 = read, 0 = write.
- core_addr  in  ADDR_W  core address.
- core_be  in  4  core byte enables.
- core_din  in  32  core write data.
- core_dout  out  32  core read data.
- core_ready  out  1  core done pulse.
- aux_req  in  1  aux request pulse.
- aux_rnw  in  1  aux access type.
- aux_addr  in  ADDR_W  aux address.
- aux_be  in  4  aux byte enables.
- aux_din  in  32  aux write data.
- aux_dout  out  32  aux read data.
- aux_ready  out  1  aux done pulse.
- mem_ena  out  1  controller request pulse.
- mem_rnw  out  1  controller access type.
- mem_Adr  out  ADDR_W  controller address.
- mem_be  out  4  controller byte enables.
- mem_dataWrite  out  32  controller write data.
- mem_done  in  1  controller completion pulse.
- mem_dataRead  in  32  controller read data.
- drop_err  out  1  sticky flag: a request was dropped.
- timeout_err  out  1  sticky flag: a watchdog abort occurred.

Behaviour:
- Reset values: every output is 0, every pending flag is 0, state = IDLE, starvation counter = 0, round-robin pointer = core.
- Capture: a req high at clock edge E sets that channel's pending flag and latches its addr/be/din/rnw at E. Download is always write with be = 4'hF.
- Drop rule: a req while the same channel is already pending, or is granted and not yet complete, is dropped and drop_err is set. The original request is unaffected.
- States: IDLE -> ISSUE -> WAIT -> IDLE.
- IDLE: at the first edge with any pending flag set, pick a winner, drive mem_* from the winner's latch, assert mem_ena for exactly one cycle, and go to ISSUE.
- ISSUE: lasts one cycle, then go to WAIT. mem_Adr, mem_be, mem_rnw and mem_dataWrite stay stable from ISSUE until completion.
- WAIT: at the edge where mem_done = 1:
  - pulse the winner's ready for one cycle;
  - register mem_dataRead into the winner's dout (dout holds until that channel's next completion);
  - clear the winner's pending flag;
  - return to IDLE.
- mem_done while in IDLE or ISSUE is ignored.
- Latency: req edge to mem_ena high is 2 cycles minimum. mem_done edge to ready high is 1 cycle. Back-to-back grants are spaced by at least 1 IDLE cycle.
- Priority: download > core > aux, with one exception. Core grants made while aux is pending increment the starvation counter. When the counter reaches STARVE_LIMIT and aux is pending, aux wins over core; download still wins over both. The counter clears on any aux grant and whenever aux is not pending.
- Simultaneous events: a req arriving on the same edge its channel's ready is produced is accepted, not dropped, because the flag is cleared before the set takes effect. Requests on all three channels in the same cycle are served in order dl, core, aux.
- Reset mid-operation: an asynchronous reset discards all pending requests and any in-flight request. A late mem_done after reset is ignored because state = IDLE.
- drop_err and timeout_err clear only on reset.

Optional Feature:
- Macro: SDRAM_ARB_TIMEOUT_EN.
- Enabled: a 13-bit watchdog counts cycles spent in WAIT. When it reaches TIMEOUT, the arbiter pulses the winner's ready, forces that channel's dout to 32'hDEADDEAD, sets timeout_err, and returns to IDLE.
- Disabled: no counter; timeout_err is tied to 0 and WAIT holds indefinitely.

Test Plan:
- Single core read: core_req at addr 0x0800010 with controller done 5 cycles after mem_ena, mem_dataRead = 0x12345678 -> mem_ena 2 cycles after req; core_ready 1 cycle after done; core_dout = 0x12345678.
- Simultaneous dl, core and aux requests in one cycle -> three mem_ena pulses in order dl, core, aux; each ready arrives only after the preceding done.
- Starvation: aux pending while core re-requests continuously, STARVE_LIMIT = 8 -> exactly 8 core grants, then 1 aux grant.
- Drop: second core_req before core_ready -> drop_err = 1, exactly one mem_ena, original address preserved.
- Reset asserted during WAIT, then a mem_done pulse -> all outputs 0, no ready pulse, next request served normally.
- With SDRAM_ARB_TIMEOUT_EN and TIMEOUT = 16, mem_done never asserted -> aux_ready 16 cycles into WAIT, aux_dout = 0xDEADDEAD, timeout_err = 1.
